// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the iterative integer square root (sqrt_iter).
package sqrt_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  // Ceiling log2 for sizing the iteration counter; evaluated at elaboration.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage : sqrt_pkg

// File: rtl/sqrt_step.sv
// One digit-by-digit square-root iteration: trial-subtract (acc | m) from the
// partial remainder and shift the root accumulator right by one.
module sqrt_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] xr_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] xr_next_o,
  output logic [WIDTH-1:0] acc_next_o
);

  logic [WIDTH-1:0] b;

  // NOTE: every output gets a default first so no path through the block can
  // leave it unassigned and infer a latch.
  always_comb begin
    b          = acc_i | m_i;
    xr_next_o  = xr_i;
    acc_next_o = acc_i >> 1;
    if (xr_i >= b) begin
      xr_next_o  = xr_i - b;
      acc_next_o = (acc_i >> 1) | m_i;
    end
  end

endmodule : sqrt_step

// File: rtl/sqrt_iter.sv
// Iterative floor(sqrt(x)) with start/busy handshake and one-cycle done pulse.
// Define SQRT_REM_EN to add the rem_bo output (x - y*y).
module sqrt_iter
  import sqrt_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int N     = WIDTH / 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] x_bi,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
`ifdef SQRT_REM_EN
  output logic [N:0]       rem_bo,
`endif
  output logic [N-1:0]     y_bo
);

  localparam int CW = clog2(N);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("sqrt_iter: WIDTH must be even and >= 4");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] xr_q, xr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     y_q, y_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_xr, step_acc;
`ifdef SQRT_REM_EN
  logic [N:0]       rem_q, rem_d;
`endif

  sqrt_step #(.WIDTH(WIDTH)) u_step (
    .xr_i       (xr_q),
    .acc_i      (acc_q),
    .m_i        (m_q),
    .xr_next_o  (step_xr),
    .acc_next_o (step_acc)
  );

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    acc_d   = acc_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    done_d  = 1'b0;
`ifdef SQRT_REM_EN
    rem_d   = rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          xr_d    = x_bi;
          acc_d   = '0;
          m_d     = WIDTH'(1) << (WIDTH - 2);
          cnt_d   = CW'(N - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        xr_d  = step_xr;
        acc_d = step_acc;
        m_d   = m_q >> 2;
        cnt_d = cnt_q - 1'b1;
        // The last step's outputs go straight to the result registers.
        if (cnt_q == '0) begin
          y_d     = step_acc[N-1:0];
`ifdef SQRT_REM_EN
          rem_d   = step_xr[N:0];
`endif
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      xr_q    <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
`ifdef SQRT_REM_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      done_q  <= done_d;
`ifdef SQRT_REM_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign busy_o = (state_q == CALC);
  assign done_o = done_q;
  assign y_bo   = y_q;
`ifdef SQRT_REM_EN
  assign rem_bo = rem_q;
`endif

endmodule : sqrt_iter

// File: tb/tb_sqrt_iter.sv
// Bench for sqrt_iter: WIDTH=8 and WIDTH=16 instances against a cycle-level
// reference model plus directed literal expectations. Honours SQRT_REM_EN.
module tb_sqrt_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s8  = 1'b0;
  logic        s16 = 1'b0;
  logic [7:0]  x8  = '0;
  logic [15:0] x16 = '0;
  logic        busy8, done8, busy16, done16;
  logic [3:0]  y8;
  logic [7:0]  y16;
`ifdef SQRT_REM_EN
  logic [4:0]  rem8;
  logic [8:0]  rem16;
`endif

  always #5 clk = ~clk;

  sqrt_iter #(.WIDTH(8)) dut8 (
    .clk_i   (clk),
    .rst_i   (rst),
    .x_bi    (x8),
    .start_i (s8),
    .busy_o  (busy8),
    .done_o  (done8),
`ifdef SQRT_REM_EN
    .rem_bo  (rem8),
`endif
    .y_bo    (y8)
  );

  sqrt_iter #(.WIDTH(16)) dut16 (
    .clk_i   (clk),
    .rst_i   (rst),
    .x_bi    (x16),
    .start_i (s16),
    .busy_o  (busy16),
    .done_o  (done16),
`ifdef SQRT_REM_EN
    .rem_bo  (rem16),
`endif
    .y_bo    (y16)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic longint isqrt(input longint v);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Reference model: a result appears N cycles after acceptance, computed
  // directly as floor(sqrt(x)) and x - y*y.
  int     m8_cnt = 0, m16_cnt = 0;
  longint m8_x = 0, m16_x = 0, m8_y = 0, m16_y = 0, m8_rem = 0, m16_rem = 0;
  bit     m8_done = 0, m16_done = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m8_cnt = 0;  m8_done = 0;  m8_y = 0;  m8_rem = 0;
      m16_cnt = 0; m16_done = 0; m16_y = 0; m16_rem = 0;
    end else begin
      m8_done = 0;
      if (m8_cnt == 0) begin
        if (s8) begin m8_x = longint'(x8); m8_cnt = 4; end
      end else begin
        m8_cnt--;
        if (m8_cnt == 0) begin
          m8_y = isqrt(m8_x); m8_rem = m8_x - m8_y * m8_y; m8_done = 1;
        end
      end
      m16_done = 0;
      if (m16_cnt == 0) begin
        if (s16) begin m16_x = longint'(x16); m16_cnt = 8; end
      end else begin
        m16_cnt--;
        if (m16_cnt == 0) begin
          m16_y = isqrt(m16_x); m16_rem = m16_x - m16_y * m16_y; m16_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy8",  64'(busy8),  64'(m8_cnt != 0));
      check("done8",  64'(done8),  64'(m8_done));
      check("y8",     64'(y8),     m8_y);
      check("busy16", 64'(busy16), 64'(m16_cnt != 0));
      check("done16", 64'(done16), 64'(m16_done));
      check("y16",    64'(y16),    m16_y);
`ifdef SQRT_REM_EN
      check("rem8",   64'(rem8),   m8_rem);
      check("rem16",  64'(rem16),  m16_rem);
`endif
    end
  end

  task automatic go8(input logic [7:0] x, output int cycles, output int busy_cnt);
    @(negedge clk); x8 = x; s8 = 1'b1;
    @(negedge clk); s8 = 1'b0;
    cycles = 0; busy_cnt = 0;
    while (!done8 && cycles < 40) begin
      busy_cnt += int'(busy8);
      @(negedge clk); cycles++;
    end
    check("done8_seen", 64'(done8), 64'd1);
  endtask

  task automatic go16(input logic [15:0] x, output int cycles, output int busy_cnt);
    @(negedge clk); x16 = x; s16 = 1'b1;
    @(negedge clk); s16 = 1'b0;
    cycles = 0; busy_cnt = 0;
    while (!done16 && cycles < 40) begin
      busy_cnt += int'(busy16);
      @(negedge clk); cycles++;
    end
    check("done16_seen", 64'(done16), 64'd1);
  endtask

  typedef struct { logic [15:0] x; int y; int rem; } vec_t;
  vec_t vecs[3] = '{'{16'd50, 7, 1}, '{16'hFFFF, 255, 510}, '{16'd0, 0, 0}};

  initial begin
    int cyc, bc, dones, yv;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    check("rst_y16",    64'(y16),    64'd0);
    check("rst_busy16", 64'(busy16), 64'd0);
    check("rst_done16", 64'(done16), 64'd0);
    check("rst_y8",     64'(y8),     64'd0);
    rst = 1'b1;

    // Perfect squares on the 8-bit instance.
    for (int i = 0; i < 16; i++) begin
      go8(8'(i * i), cyc, bc);
      check("sq8_y",       64'(y8),    64'(i));
      check("sq8_latency", 64'(cyc),   64'd4);
      check("sq8_busy",    64'(bc),    64'd4);
      check("sq8_idle",    64'(busy8), 64'd0);
    end

    // Directed 16-bit operands including the extremes.
    foreach (vecs[k]) begin
      go16(vecs[k].x, cyc, bc);
      check("v16_y",       64'(y16), 64'(vecs[k].y));
`ifdef SQRT_REM_EN
      check("v16_rem",     64'(rem16), 64'(vecs[k].rem));
`endif
      check("v16_latency", 64'(cyc), 64'd8);
      check("v16_busy",    64'(bc),  64'd8);
    end

    // start held during CALC must be ignored.
    @(negedge clk); x16 = 16'd100; s16 = 1'b1;
    @(negedge clk); x16 = 16'd9;
    dones = 0; yv = -1;
    for (int c = 0; c < 24; c++) begin
      if (done16) begin dones++; s16 = 1'b0; yv = int'(y16); end
      @(negedge clk);
    end
    s16 = 1'b0;
    check("hold_dones", 64'(dones), 64'd1);
    check("hold_y",     64'(yv),    64'd10);

    // Back-to-back: restart in the done cycle.
    go16(16'd144, cyc, bc);
    check("b2b_y1", 64'(y16), 64'd12);
    x16 = 16'd169; s16 = 1'b1;
    check("b2b_gap", 64'(busy16), 64'd0);
    @(negedge clk); s16 = 1'b0;
    check("b2b_busy", 64'(busy16), 64'd1);
    cyc = 0;
    while (!done16 && cyc < 40) begin @(negedge clk); cyc++; end
    check("b2b_y2",      64'(y16), 64'd13);
    check("b2b_latency", 64'(cyc), 64'd8);

    // Reset on the third CALC edge aborts the operation.
    @(negedge clk); x16 = 16'd400; s16 = 1'b1;
    @(negedge clk); s16 = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    check("abort_busy", 64'(busy16), 64'd0);
    check("abort_y",    64'(y16),    64'd0);
    check("abort_done", 64'(done16), 64'd0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      dones += int'(done16);
      @(negedge clk);
    end
    check("abort_no_done", 64'(dones), 64'd0);
    go16(16'd400, cyc, bc);
    check("after_abort_y", 64'(y16), 64'd20);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_sqrt_iter
